// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Fixed 34-cycle latency: capture, DATA_WIDTH shift-add/restoring iterations, sign fix-up, done pulse.
module ex_muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic [4:0]            i_rd_addr,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [4:0]            o_rd_addr
);

  localparam int unsigned   W        = DATA_WIDTH;
  localparam int unsigned   CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [2:0]    func3_q, func3_d;
  logic [4:0]    rd_q, rd_d;
  logic          neg_q, neg_d;
  logic          div0_q, div0_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [W-1:0]  result_q, result_d;
  logic [4:0]    rd_out_q, rd_out_d;

  // Operand decode at the start edge
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         op_div0, op_ovf, op_neg;

  always_comb begin
    a_signed = (i_func3 == 3'b001) || (i_func3 == 3'b010) ||
               (i_func3 == 3'b100) || (i_func3 == 3'b110);
    b_signed = (i_func3 == 3'b001) || (i_func3 == 3'b100) || (i_func3 == 3'b110);
    a_neg    = a_signed & i_rs1_data[W-1];
    b_neg    = b_signed & i_rs2_data[W-1];
    a_mag    = a_neg ? -i_rs1_data : i_rs1_data;
    b_mag    = b_neg ? -i_rs2_data : i_rs2_data;
    op_div0  = i_func3[2] && (i_rs2_data == '0);
    op_ovf   = i_func3[2] && !i_func3[0] && (i_rs1_data == MIN_NEG) && (i_rs2_data == '1);
    // remainder follows the dividend; products and quotients follow the XOR of signs
    op_neg   = (i_func3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration: hi:lo is the product accumulator or remainder:quotient
  logic [W-1:0] mul_addend;
  logic [W:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    mul_addend = lo_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    div_shift  = {hi_q, lo_q[W-1]};
    div_diff   = div_shift - {1'b0, opb_q};
  end

  logic [2*W-1:0] prod_mag, prod;
  logic [W-1:0]   quo, rem, fix_result;

  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod     = neg_q ? -prod_mag : prod_mag;
    quo      = neg_q ? -lo_q : lo_q;
    rem      = neg_q ? -hi_q : hi_q;
    case (func3_q)
      3'b000:                 fix_result = prod[W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*W-1:W];
      3'b100, 3'b101:         fix_result = div0_q ? '1 : (ovf_q ? MIN_NEG : quo);
      // a zero divisor leaves the signed dividend in the remainder already
      default:                fix_result = ovf_q ? '0 : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          cnt_d   = CNT_LOAD;
          hi_d    = '0;
          lo_d    = a_mag;
          opb_d   = b_mag;
          func3_d = i_func3;
          rd_d    = i_rd_addr;
          neg_d   = op_neg;
          div0_d  = op_div0;
          ovf_d   = op_ovf;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (func3_q[2]) begin
          if (!div_diff[W]) begin
            hi_d = div_diff[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
          end else begin
            hi_d = div_shift[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[W:1];
          lo_d = {mul_sum[0], lo_q[W-1:1]};
        end
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_result;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (i_flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      func3_q  <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      func3_q  <= func3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_comb begin
    o_stall = ((state_q == S_IDLE) && i_start && !i_flush) ||
              (state_q == S_RUN) || (state_q == S_FIX);
  end

  assign o_done    = done_q;
  assign o_result  = result_q;
  assign o_rd_addr = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized bench for ex_muldiv_unit against an arithmetic RV32M reference and a cycle-count timing model.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_func3 = '0;
  logic [31:0] i_rs1_data = '0;
  logic [31:0] i_rs2_data = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_flush = 1'b0;
  logic        o_stall, o_done;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;

  int checks = 0;
  int failures = 0;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_func3    (i_func3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .i_flush    (i_flush),
    .o_stall    (o_stall),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_rd_addr  (o_rd_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Timing model: m_cnt = edges since the accepted start edge; result visible at 34
  localparam int DONE_AT = 34;
  int          m_cnt = 0;
  logic [31:0] m_res = '0, m_pend = '0;
  logic [4:0]  m_rd = '0, m_pend_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_res <= '0;
      m_rd  <= '0;
    end else if (i_flush) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (i_start) begin
        m_cnt     <= 1;
        m_pend    <= ref_op(i_func3, i_rs1_data, i_rs2_data);
        m_pend_rd <= i_rd_addr;
      end
    end else if (m_cnt == DONE_AT - 1) begin
      m_cnt <= DONE_AT;
      m_res <= m_pend;
      m_rd  <= m_pend_rd;
    end else if (m_cnt == DONE_AT) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(o_stall),
        32'((m_cnt == 0 && i_start && !i_flush) || (m_cnt >= 1 && m_cnt < DONE_AT)));
    chk("done", 32'(o_done), 32'(m_cnt == DONE_AT));
    chk("result", o_result, m_res);
    chk("rd", 32'(o_rd_addr), 32'(m_rd));
  end

  // Issue one op from IDLE; called and returns at posedge+1
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_at, input bit hold, input bit chk_stalls);
    int n;
    int stalls;
    bit got;
    i_start    = 1'b1;
    i_func3    = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    i_flush    = (flush_at == 0);
    n = 0;
    stalls = 0;
    got = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      if (n > 0 && o_stall) stalls++;
      if (o_done) got = 1'b1;
      @(posedge clk); #1;
      if (got || n == flush_at) break;
      n++;
      i_rs1_data = $urandom;
      i_rs2_data = $urandom;
      i_flush    = (n == flush_at);
      if (n >= DONE_AT && !hold) i_start = 1'b0;
    end
    i_start = 1'b0;
    i_flush = 1'b0;
    if (flush_at < 0) begin
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(n), 32'(DONE_AT));
      if (chk_stalls) chk("stall_cycles", 32'(stalls), 32'd33);
    end else begin
      chk("flush_no_done", 32'(got), 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    vecs[8]  = '{3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(o_stall), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_result", o_result, 32'd0);
    chk("reset_rd", 32'(o_rd_addr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) chk("model_pin", ref_op(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].r);

    // Directed ops back to back, i_start held through DONE
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), -1, 1'b1, (i == 0));
      chk("directed_result", o_result, vecs[i].r);
      chk("directed_rd", 32'(o_rd_addr), 32'(i + 1));
    end

    // Flush in RUN cycle 10, then flush racing a start in IDLE
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 10, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_stall_low", 32'(o_stall), 32'd0);
    chk("flush_result_held", o_result, vecs[11].r);
    @(posedge clk); #1;
    run_op(3'd5, 32'd50, 32'd5, 5'd4, 0, 1'b0, 1'b0);

    // Reset pulse in RUN cycle 20
    run_op(3'd0, 32'd3, 32'd4, 5'd9, -1, 1'b0, 1'b0);
    i_start = 1'b1; i_func3 = 3'd5; i_rs1_data = 32'd1000; i_rs2_data = 32'd3; i_rd_addr = 5'd12;
    repeat (21) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    chk("midreset_done", 32'(o_done), 32'd0);
    chk("midreset_result", o_result, 32'd0);
    chk("midreset_rd", 32'(o_rd_addr), 32'd0);
    chk("midreset_stall", 32'(o_stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 60; k++) begin
      int fl;
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 33)) : -1;
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), fl,
             1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
